// File: rtl/conv_ctrl.sv
// conv_ctrl: job scheduler for the 3x3 conv engine; latches a job, feeds FEED_LEN strobes,
// buffers the engine result behind valid/ready and recovers the engine on abort or timeout.
module conv_ctrl #(
  parameter int TIMEOUT  = 32,
  parameter int FEED_LEN = 324
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_vld,
  output logic         job_rdy,
  input  logic [511:0] job_data,
  input  logic [215:0] job_weight,
  input  logic         abort,
  input  logic         err_clr,
  output logic         conv_in_vld,
  output logic [511:0] conv_data_lin,
  output logic [215:0] conv_weight_lin,
  output logic         conv_rst_n,
  input  logic         conv_out_vld,
  input  logic [863:0] conv_lin,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [863:0] res_data,
  output logic         busy,
  output logic         err
);
  localparam int FW = $clog2(FEED_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FEED_LAST = FW'(FEED_LEN - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, FEED, WAIT, HOLD} state_t;
  state_t        r_state, w_next;
  logic [FW-1:0] r_feed_cnt;
  logic [TW-1:0] r_wait_cnt;
  logic          r_in_vld, r_rst_n, r_res_vld, r_err;
  logic [511:0]  r_data;
  logic [215:0]  r_weight;
  logic [863:0]  r_res_data;
  logic          w_accept, w_abort, w_feed_done, w_timeout, w_cap, w_proto_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = job_vld ? FEED : IDLE;
      FEED:    w_next = w_feed_done ? WAIT : FEED;
      WAIT:    w_next = conv_out_vld ? (w_cap ? IDLE : HOLD) : (w_timeout ? IDLE : WAIT);
      HOLD:    w_next = res_rdy ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  // abort outranks capture and timeout, so both are qualified with !w_abort
  always_comb begin
    job_rdy     = r_state == IDLE;
    busy        = r_state != IDLE;
    w_accept    = job_rdy && job_vld;
    w_abort     = abort && busy;
    w_feed_done = r_state == FEED && r_feed_cnt == FEED_LAST;
    w_timeout   = !w_abort && r_state == WAIT && !conv_out_vld && r_wait_cnt == WAIT_LAST;
    w_cap       = !w_abort && ((r_state == WAIT && conv_out_vld && (!r_res_vld || res_rdy)) ||
                               (r_state == HOLD && res_rdy));
    w_proto_err = conv_out_vld && (r_state == IDLE || r_state == FEED);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_in_vld   <= 1'b0;
      r_rst_n    <= 1'b0;
      r_feed_cnt <= '0;
      r_wait_cnt <= '0;
      r_data     <= '0;
      r_weight   <= '0;
      r_res_data <= '0;
      r_res_vld  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_vld   <= w_next == FEED;
      r_rst_n    <= !(w_abort || w_timeout);
      r_feed_cnt <= w_accept ? '0 : (r_state == FEED ? r_feed_cnt + 1'b1 : r_feed_cnt);
      r_wait_cnt <= w_feed_done ? '0 : (r_state == WAIT ? r_wait_cnt + 1'b1 : r_wait_cnt);
      if (w_accept) begin
        r_data   <= job_data;
        r_weight <= job_weight;
      end
      if (w_cap) r_res_data <= conv_lin;
      r_res_vld  <= w_cap || (r_res_vld && !res_rdy);
      r_err      <= w_timeout || w_proto_err || (r_err && !err_clr);
    end
  assign conv_in_vld     = r_in_vld;
  assign conv_rst_n      = r_rst_n;
  assign conv_data_lin   = r_data;
  assign conv_weight_lin = r_weight;
  assign res_vld         = r_res_vld;
  assign res_data        = r_res_data;
  assign err             = r_err;
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: table-driven job scenarios, hand-written corner sequences and a random phase,
// with a result scoreboard and rule-based expectations for strobes, timeouts and errors.
module tb_conv_ctrl;
  localparam int TIMEOUT  = 32;
  localparam int FEED_LEN = 324;
  logic         clk, rst, job_vld, job_rdy, abort, err_clr, conv_in_vld, conv_rst_n;
  logic         conv_out_vld, res_vld, res_rdy, busy, err;
  logic [511:0] job_data, conv_data_lin;
  logic [215:0] job_weight, conv_weight_lin;
  logic [863:0] conv_lin, res_data;
  int checks = 0, errors = 0, pops = 0;
  bit rnd_rdy = 0;
  logic [863:0] sb[$];
  typedef struct {int delay; int abort_at; bit exp_err; int exp_res;} vec_t;
  vec_t tbl[7];

  conv_ctrl #(.TIMEOUT(TIMEOUT), .FEED_LEN(FEED_LEN)) dut (
    .clk(clk), .rst(rst), .job_vld(job_vld), .job_rdy(job_rdy), .job_data(job_data),
    .job_weight(job_weight), .abort(abort), .err_clr(err_clr), .conv_in_vld(conv_in_vld),
    .conv_data_lin(conv_data_lin), .conv_weight_lin(conv_weight_lin), .conv_rst_n(conv_rst_n),
    .conv_out_vld(conv_out_vld), .conv_lin(conv_lin), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_data(res_data), .busy(busy), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [863:0] act, input logic [863:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [863:0] rnd_bits();
    logic [863:0] v;
    for (int i = 0; i < 27; i++) v[i*32+:32] = $urandom;
    return v;
  endfunction

  // one clock: observe the handshake mid-cycle, then step to just after the next edge
  task automatic tick();
    @(negedge clk);
    if (res_vld && res_rdy) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("res_data_sb", res_data, sb.pop_front());
      pops++;
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) res_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_err();
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_job_rdy", job_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_vld", conv_in_vld, 0);
    chk("rst_conv_rst_n", conv_rst_n, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_data_lin", conv_data_lin, 0);
    chk("rst_weight_lin", conv_weight_lin, 0);
  endtask

  // delay: engine pulses conv_out_vld in cycle L+delay (L = last strobe); -1 = never
  task automatic run_job(input int delay, input int abort_at, input bit chk_res, output logic [863:0] r);
    logic [863:0] t;
    logic [511:0] d;
    logic [215:0] w;
    int k = 0, n = 0;
    t = rnd_bits(); d = t[511:0];
    t = rnd_bits(); w = t[215:0];
    r = rnd_bits();
    while (!job_rdy && k < 300) begin tick(); k++; end
    chk("job_rdy_wait", job_rdy, 1);
    job_vld = 1; job_data = d; job_weight = w;
    tick();
    job_vld = 0; job_data = ~d; job_weight = ~w;
    chk("busy_after_accept", busy, 1);
    chk("job_rdy_after_accept", job_rdy, 0);
    while (conv_in_vld && n < FEED_LEN + 10) begin
      if (n == abort_at) abort = 1;
      tick();
      abort = 0;
      n++;
    end
    chk("strobes", n, abort_at >= 0 ? abort_at + 1 : FEED_LEN);
    chk("data_lin", conv_data_lin, d);
    chk("weight_lin", conv_weight_lin, w);
    if (abort_at >= 0) begin
      chk("abort_rst_n_low", conv_rst_n, 0);
      chk("abort_idle", job_rdy, 1);
      tick();
      chk("abort_rst_n_high", conv_rst_n, 1);
    end else if (delay < 0) begin
      repeat (TIMEOUT - 1) tick();
      chk("pre_timeout_rst_n", conv_rst_n, 1);
      chk("pre_timeout_err", err, 0);
      tick();
      chk("timeout_rst_n", conv_rst_n, 0);
      chk("timeout_err", err, 1);
      chk("timeout_idle", job_rdy, 1);
      tick();
      chk("timeout_rst_n_back", conv_rst_n, 1);
    end else begin
      repeat (delay - 1) tick();
      conv_out_vld = 1; conv_lin = r;
      sb.push_back(r);
      tick();
      conv_out_vld = 0;
      if (chk_res) begin
        chk("cap_res_vld", res_vld, 1);
        chk("cap_res_data", res_data, r);
        chk("cap_idle", job_rdy, 1);
      end
    end
  endtask

  initial begin
    logic [863:0] r1, r2;
    int p0, dly, ab;
    tbl[0] = '{3, -1, 1'b0, 1};
    tbl[1] = '{1, -1, 1'b0, 1};
    tbl[2] = '{TIMEOUT, -1, 1'b0, 1};
    tbl[3] = '{-1, -1, 1'b1, 0};
    tbl[4] = '{5, 100, 1'b0, 0};
    tbl[5] = '{5, 0, 1'b0, 0};
    tbl[6] = '{5, FEED_LEN - 1, 1'b0, 0};
    rst = 1; job_vld = 0; abort = 0; err_clr = 0; conv_out_vld = 0; res_rdy = 1;
    job_data = '0; job_weight = '0; conv_lin = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 0;
    #1;
    chk("rst_n_before_edge", conv_rst_n, 0);
    tick();
    chk("rst_n_after_edge", conv_rst_n, 1);

    // single job, ready downstream: one-cycle result pulse
    run_job(3, -1, 1, r1);
    tick();
    chk("single_res_vld_pulse", res_vld, 0);
    chk("single_err", err, 0);

    foreach (tbl[i]) begin
      clear_err();
      p0 = pops;
      run_job(tbl[i].delay, tbl[i].abort_at, 1, r1);
      tick();
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_results", i), pops - p0, tbl[i].exp_res);
    end

    // backpressure: second result waits in HOLD until the buffer drains
    clear_err();
    res_rdy = 0;
    run_job(3, -1, 1, r1);
    run_job(3, -1, 0, r2);
    chk("hold_busy", busy, 1);
    chk("hold_job_rdy", job_rdy, 0);
    chk("hold_res_data", res_data, r1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hold_res_vld", res_vld, 1);
    end
    chk("hold_keep_data", res_data, r1);
    res_rdy = 1;
    tick();
    chk("hold_cap_data", res_data, r2);
    chk("hold_cap_vld", res_vld, 1);
    chk("hold_cap_idle", job_rdy, 1);
    tick();
    chk("hold_drained", res_vld, 0);
    chk("hold_err", err, 0);

    // spurious engine pulse in IDLE, err_clr, and err_clr racing a new error
    abort = 1;
    tick();
    abort = 0;
    chk("idle_abort_ignored", conv_rst_n, 1);
    conv_out_vld = 1;
    tick();
    conv_out_vld = 0;
    chk("spurious_err_set", err, 1);
    chk("spurious_no_res", res_vld, 0);
    clear_err();
    chk("err_cleared", err, 0);
    err_clr = 1; conv_out_vld = 1;
    tick();
    err_clr = 0; conv_out_vld = 0;
    chk("err_set_wins", err, 1);
    clear_err();

    // asynchronous reset in WAIT
    job_vld = 1; job_data = {16{32'hdeadbeef}}; job_weight = '1;
    tick();
    job_vld = 0;
    for (int i = 0; i < FEED_LEN + 10 && conv_in_vld; i++) tick();
    repeat (5) tick();
    chk("wait_busy", busy, 1);
    #2 rst = 1;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_release_rst_n", conv_rst_n, 0);
    tick();
    chk("rst_release_edge_rst_n", conv_rst_n, 1);
    chk("rst_release_idle", job_rdy, 1);

    // random phase with random downstream backpressure
    rnd_rdy = 1;
    for (int j = 0; j < 25; j++) begin
      clear_err();
      dly = $urandom_range(0, 5) == 0 ? -1 : int'($urandom_range(1, TIMEOUT));
      ab  = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, FEED_LEN - 1)) : -1;
      run_job(dly, ab, 0, r1);
      tick();
      chk("rnd_err", err, dly < 0 && ab < 0);
    end
    rnd_rdy = 0;
    res_rdy = 1;
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    chk("final_res_vld", res_vld, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_ctrl.md
# conv_ctrl

Job-level scheduler for the 3-channel 3x3 convolution engine. It accepts one job at a time (an 8x8 input tile plus a 3x3x3 weight set), latches the job into stable registers, and drives the engine's `in_vld` for exactly 324 cycles (36 windows x 9 taps). It then waits for the engine's completion strobe and captures the 6x6x3 result into a one-deep output buffer with a valid/ready handshake. It also recovers the engine through a reset pulse on abort or timeout.

## Interface
- `TIMEOUT`, default 32: max cycles in WAIT before declaring the engine hung.
- `FEED_LEN`, default 324: engine input strobes per job (36 x 9).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `job_vld`  in  1  upstream job valid.
- `job_rdy`  out  1  controller can accept a job.
- `job_data`  in  512  8x8x8-bit tile, same packing as engine `data_lin`.
- `job_weight`  in  216  3x3x3x8-bit weights, same packing as engine `weight_lin`.
- `abort`  in  1  cancel the current job.
- `err_clr`  in  1  clear the sticky error.
- `conv_in_vld`  out  1  engine input strobe.
- `conv_data_lin`  out  512  latched tile.
- `conv_weight_lin`  out  216  latched weights.
- `conv_rst_n`  out  1  engine reset, active low, registered.
- `conv_out_vld`  in  1  engine completion pulse.
- `conv_lin`  in  864  engine result (6x6x3x8).
- `res_vld`  out  1  result buffer full.
- `res_rdy`  in  1  downstream accepts the result.
- `res_data`  out  864  buffered result.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, FEED, WAIT, HOLD.
- IDLE
  - `job_rdy=1`.
  - On `job_vld&&job_rdy`: latch `job_data`/`job_weight` into the `conv_*_lin` registers, clear `feed_cnt`, go to FEED.
- FEED
  - `conv_in_vld=1` every cycle; `feed_cnt` increments.
  - At `feed_cnt==FEED_LEN-1`: go to WAIT and clear `wait_cnt`.
  - There is no stall inside FEED.
- WAIT
  - `wait_cnt` increments each cycle.
  - On `conv_out_vld`:
    - If `!res_vld || res_rdy`: capture `conv_lin` into `res_data`, set `res_vld`, go to IDLE.
    - Otherwise go to HOLD.
  - If `wait_cnt==TIMEOUT-1` with no `conv_out_vld`: set `err`, pulse `conv_rst_n` low for one cycle, go to IDLE, produce no result.
- HOLD
  - `conv_lin` is stable because the engine is not fed.
  - When `res_rdy` (buffer drains): capture `conv_lin`, keep `res_vld=1`, go to IDLE.
- Result buffer
  - `res_vld` clears on `res_vld&&res_rdy` unless a capture happens in the same cycle; a capture has priority and keeps it set.
  - `res_data` holds its value while `res_vld=1`.
- `abort` in FEED/WAIT/HOLD:
  - Pulse `conv_rst_n` low for one cycle, go to IDLE, leave the result buffer untouched, do not set `err`.
  - `abort` in IDLE is ignored.
  - `abort` has priority over every other transition in the same cycle, including capture.
- `conv_out_vld` in IDLE or FEED is a protocol error: set `err` and ignore the pulse.
- `err` is sticky. `err_clr` clears it; a set event in the same cycle wins.
- The `conv_*_lin` registers change only on job acceptance.

## Timing
- Reset values:
  - state IDLE, `job_rdy=1`, `busy=0`.
  - `conv_in_vld=0`, `conv_rst_n=0`.
  - `res_vld=0`, `res_data=0`, `err=0`.
  - `conv_data_lin=0`, `conv_weight_lin=0`, all counters 0.
- `conv_rst_n` rises on the first `clk` edge after `rst` deasserts.
- `conv_in_vld` and `conv_rst_n` are registered outputs; `job_rdy` and `busy` are decoded from state.
- Job accepted at edge T: `conv_in_vld` is high for cycles T+1..T+324 exactly, and `busy` is high from T+1.
- `conv_out_vld` sampled at edge E in WAIT with the buffer free: `res_vld=1` from E+1, and state is IDLE (`job_rdy=1`) from E+1.
- Minimum job-to-job spacing is 324 + engine latency + 1 cycles.
- Timeout: `err=1` and `conv_rst_n=0` during the cycle after the edge where `wait_cnt` hits `TIMEOUT-1`; `conv_rst_n` returns to 1 one cycle later.
- `rst` asserted mid-job: all state returns to reset values immediately (asynchronous), and any in-flight result is lost.

## Test plan
- Single job, `res_rdy=1`, engine responds 3 cycles after the last strobe -> exactly 324 `conv_in_vld` cycles, `res_data==conv_lin`, `res_vld` pulses 1 cycle, `err=0`.
- Two jobs, `res_rdy=0` until 10 cycles after the second `conv_out_vld` -> controller holds in HOLD, first result kept, second captured in the cycle `res_rdy` goes high, `res_vld` never drops.
- No engine response, `TIMEOUT=32` -> `err=1` and a one-cycle `conv_rst_n=0` exactly 32 cycles after the last strobe, no `res_vld`, next job accepted normally.
- `abort` at `feed_cnt==100` -> `conv_in_vld` low the next cycle, one-cycle `conv_rst_n` pulse, `err=0`, a subsequent full job gives the correct result.
- Spurious `conv_out_vld` in IDLE, then `err_clr`, and `err_clr` coinciding with a new error -> `err` sets, clears, and stays set respectively.
- `rst` pulsed during WAIT -> all outputs return to reset values asynchronously, `conv_rst_n=0` until the first edge after release.
